// File: rtl/switch_xbar.sv
// NxN crossbar: per-output FIFO, input selected by a daisy-chained config.
// Optional SWITCH_FWD_CNT_EN adds per-output saturating forwarded-word counters.
module switch_xbar #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              in_valid,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  in_data,
  output logic [NUM_PORTS-1:0]              in_ready,
  output logic [NUM_PORTS-1:0]              out_valid,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  out_data,
  input  logic [NUM_PORTS-1:0]              out_ready,
  input  logic                              cfg_in_valid,
  input  logic [CNT_W-1:0]                  cfg_in_count,
  input  logic [$clog2(NUM_PORTS)-1:0]      cfg_in_port,
  input  logic [$clog2(NUM_PORTS)-1:0]      cfg_in_src,
  input  logic                              cfg_in_enable,
  output logic                              cfg_out_valid,
  output logic [CNT_W-1:0]                  cfg_out_count,
  output logic [$clog2(NUM_PORTS)-1:0]      cfg_out_port,
  output logic [$clog2(NUM_PORTS)-1:0]      cfg_out_src,
  output logic                              cfg_out_enable
`ifdef SWITCH_FWD_CNT_EN
  ,
  output logic [NUM_PORTS-1:0][15:0]        fwd_cnt
`endif
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] NP = (PW+1)'(NUM_PORTS);

  logic [NUM_PORTS-1:0]          en;
  logic [NUM_PORTS-1:0][PW-1:0]  src;
  logic [NUM_PORTS-1:0][AW:0]    wp;
  logic [NUM_PORTS-1:0][AW:0]    rp;
  logic [DATA_W-1:0]             mem [NUM_PORTS][FIFO_DEPTH];

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic                 cfg_fwd;
  logic                 cfg_wr;

  // Extra pointer MSB distinguishes full from empty.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      empty[j]    = (wp[j] == rp[j]);
      full[j]     = (wp[j] == {~rp[j][AW], rp[j][AW-1:0]});
      out_valid[j] = !empty[j];
      out_data[j]  = mem[j][rp[j][AW-1:0]];
      pop[j]       = !empty[j] && out_ready[j];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_ready[i] = 1'b1;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (en[j] && src[j] == PW'(i) && full[j])
          in_ready[i] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      push[j] = en[j] && in_valid[src[j]]
             && in_ready[src[j]];
    end
  end

  assign cfg_fwd = cfg_in_valid && (cfg_in_count != '0);
  assign cfg_wr  = cfg_in_valid && (cfg_in_count == '0)
                && ({1'b0, cfg_in_port} < NP)
                && ({1'b0, cfg_in_src} < NP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en  <= '0;
      src <= '0;
    end else if (cfg_wr) begin
      en[cfg_in_port]  <= cfg_in_enable;
      src[cfg_in_port] <= cfg_in_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_out_valid  <= 1'b0;
      cfg_out_count  <= '0;
      cfg_out_port   <= '0;
      cfg_out_src    <= '0;
      cfg_out_enable <= 1'b0;
    end else begin
      unique case (1'b1)
        cfg_fwd: begin
          cfg_out_valid  <= 1'b1;
          cfg_out_count  <= cfg_in_count - CNT_W'(1);
          cfg_out_port   <= cfg_in_port;
          cfg_out_src    <= cfg_in_src;
          cfg_out_enable <= cfg_in_enable;
        end
        default: begin
          cfg_out_valid  <= 1'b0;
          cfg_out_count  <= '0;
          cfg_out_port   <= '0;
          cfg_out_src    <= '0;
          cfg_out_enable <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (push[j]) wp[j] <= wp[j] + (AW+1)'(1);
        if (pop[j])  rp[j] <= rp[j] + (AW+1)'(1);
      end
    end
  end

  // Storage carries no reset; pointers alone define contents.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (push[j])
        mem[j][wp[j][AW-1:0]] <= in_data[src[j]];
    end
  end

`ifdef SWITCH_FWD_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (pop[j] && fwd_cnt[j] != 16'hFFFF)
          fwd_cnt[j] <= fwd_cnt[j] + 16'd1;
      end
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_switch_xbar.sv
// Scoreboard bench for switch_xbar: per-output expected queues
// filled as words are offered, drained as the DUT presents them.
module tb_switch_xbar;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        in_valid;
  logic [3:0][31:0]  in_data;
  logic [3:0]        in_ready;
  logic [3:0]        out_valid;
  logic [3:0][31:0]  out_data;
  logic [3:0]        out_ready;
  logic              cfg_in_valid;
  logic [7:0]        cfg_in_count;
  logic [1:0]        cfg_in_port;
  logic [1:0]        cfg_in_src;
  logic              cfg_in_enable;
  logic              cfg_out_valid;
  logic [7:0]        cfg_out_count;
  logic [1:0]        cfg_out_port;
  logic [1:0]        cfg_out_src;
  logic              cfg_out_enable;
`ifdef SWITCH_FWD_CNT_EN
  logic [3:0][15:0]  fwd_cnt;
`endif

  switch_xbar dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .cfg_in_valid   (cfg_in_valid),
    .cfg_in_count   (cfg_in_count),
    .cfg_in_port    (cfg_in_port),
    .cfg_in_src     (cfg_in_src),
    .cfg_in_enable  (cfg_in_enable),
    .cfg_out_valid  (cfg_out_valid),
    .cfg_out_count  (cfg_out_count),
    .cfg_out_port   (cfg_out_port),
    .cfg_out_src    (cfg_out_src),
    .cfg_out_enable (cfg_out_enable)
`ifdef SWITCH_FWD_CNT_EN
    ,
    .fwd_cnt        (fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] q [4][$];
  logic        m_en  [4];
  logic [1:0]  m_src [4];
  int          m_cnt [4];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < 4; j++) begin
      q[j].delete();
      m_en[j]  = 1'b0;
      m_src[j] = 2'd0;
      m_cnt[j] = 0;
    end
  endtask

  // Checks comb outputs mid-cycle, then advances one edge.
  task automatic tick();
    logic [3:0]  er;
    logic [3:0]  pp;
    logic [3:0]  pu;
    logic [31:0] dd [4];
    logic [31:0] ecfg;
    logic        wr;
    logic [1:0]  wp;
    logic [1:0]  ws;
    logic        we;
    er = '1;
    for (int j = 0; j < 4; j++)
      if (m_en[j] && q[j].size() >= 4)
        er[m_src[j]] = 1'b0;
    chk("in_ready", 32'(in_ready), 32'(er));
    for (int j = 0; j < 4; j++) begin
      pp[j] = 1'b0;
      chk($sformatf("out_valid%0d", j),
          32'(out_valid[j]), 32'(q[j].size() != 0));
      if (q[j].size() != 0) begin
        chk($sformatf("out_data%0d", j),
            out_data[j], q[j][0]);
        pp[j] = out_ready[j];
      end
      pu[j] = m_en[j] && in_valid[m_src[j]]
           && er[m_src[j]];
      dd[j] = in_data[m_src[j]];
    end
    wr = cfg_in_valid && cfg_in_count == 8'd0;
    wp = cfg_in_port;
    ws = cfg_in_src;
    we = cfg_in_enable;
    ecfg = '0;
    if (cfg_in_valid && cfg_in_count != 8'd0)
      ecfg = {18'd0, 1'b1, cfg_in_count - 8'd1,
              cfg_in_port, cfg_in_src, cfg_in_enable};
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      if (pp[j]) begin
        void'(q[j].pop_front());
        if (m_cnt[j] < 16'hFFFF) m_cnt[j]++;
      end
      if (pu[j]) q[j].push_back(dd[j]);
    end
    if (wr) begin
      m_en[wp]  = we;
      m_src[wp] = ws;
    end
    chk("cfg_out", {18'd0, cfg_out_valid, cfg_out_count,
                    cfg_out_port, cfg_out_src,
                    cfg_out_enable}, ecfg);
`ifdef SWITCH_FWD_CNT_EN
    for (int j = 0; j < 4; j++)
      chk($sformatf("fwd_cnt%0d", j),
          32'(fwd_cnt[j]), 32'(m_cnt[j]));
`endif
  endtask

  task automatic cfg(input logic [1:0] p,
                     input logic [1:0] s,
                     input logic e);
    cfg_in_valid  = 1'b1;
    cfg_in_count  = 8'd0;
    cfg_in_port   = p;
    cfg_in_src    = s;
    cfg_in_enable = e;
    tick();
    cfg_in_valid  = 1'b0;
    cfg_in_port   = 2'd0;
    cfg_in_src    = 2'd0;
    cfg_in_enable = 1'b0;
  endtask

  task automatic push1(input int i, input logic [31:0] d);
    in_valid    = 4'b0001 << i;
    in_data[i]  = d;
    tick();
    in_valid    = 4'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = '0;
    in_data       = '0;
    out_ready     = '0;
    cfg_in_valid  = 1'b0;
    cfg_in_count  = '0;
    cfg_in_port   = '0;
    cfg_in_src    = '0;
    cfg_in_enable = 1'b0;
    model_clear();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'hF);
    chk("rst_cfg_valid", 32'(cfg_out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // hop-count forwarding leaves local routing alone
    cfg_in_valid  = 1'b1;
    cfg_in_count  = 8'd2;
    cfg_in_port   = 2'd1;
    cfg_in_src    = 2'd3;
    cfg_in_enable = 1'b1;
    tick();
    chk("fwd_count", 32'(cfg_out_count), 32'd1);
    cfg_in_valid  = 1'b0;
    cfg_in_count  = 8'd0;
    tick();
    push1(3, 32'h1111_2222);
    idle(2);

    // single route out2 <- in1
    out_ready = 4'hF;
    cfg(2'd2, 2'd1, 1'b1);
    push1(1, 32'hA5A5_A5A5);
    chk("route_vld", 32'(out_valid[2]), 32'd1);
    chk("route_dat", out_data[2], 32'hA5A5_A5A5);
    idle(2);

    // multicast out0,out3 <- in2 with out3 stalled
    cfg(2'd2, 2'd1, 1'b0);
    cfg(2'd0, 2'd2, 1'b1);
    cfg(2'd3, 2'd2, 1'b1);
    out_ready = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      if (k == 4)
        chk("mc_rdy5", 32'(in_ready[2]), 32'd0);
      push1(2, 32'hC000_0000 + 32'(k));
    end
    idle(2);
    out_ready = 4'b1001;
    idle(6);

    // fill out1 then reroute; push races with the write
    cfg(2'd0, 2'd2, 1'b0);
    cfg(2'd3, 2'd2, 1'b0);
    cfg(2'd1, 2'd0, 1'b1);
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++)
      push1(0, 32'hD000_0000 + 32'(k));
    in_valid   = 4'b0001;
    in_data[0] = 32'hDEAD_0000;
    cfg(2'd1, 2'd3, 1'b1);
    in_valid   = 4'b0;
    out_ready  = 4'b0010;
    for (int k = 0; k < 3; k++)
      push1(3, 32'hE000_0000 + 32'(k));
    idle(6);

    // write and push in the same cycle use the old route
    in_valid   = 4'b0001;
    in_data[0] = 32'hBEEF_0001;
    cfg(2'd2, 2'd0, 1'b1);
    in_valid   = 4'b0;
    out_ready  = 4'hF;
    idle(2);

    // randomized traffic and reconfiguration
    for (int c = 0; c < 300; c++) begin
      in_valid  = 4'($urandom);
      out_ready = 4'($urandom);
      for (int i = 0; i < 4; i++)
        in_data[i] = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        cfg_in_valid  = 1'b1;
        cfg_in_count  = 8'($urandom_range(0, 2));
        cfg_in_port   = 2'($urandom);
        cfg_in_src    = 2'($urandom);
        cfg_in_enable = 1'($urandom);
      end
      tick();
      cfg_in_valid = 1'b0;
      cfg_in_count = 8'd0;
    end
    in_valid  = 4'b0;
    out_ready = 4'hF;
    idle(6);

    // reset with three words queued
    for (int j = 0; j < 4; j++)
      cfg(2'(j), 2'd0, 1'b0);
    cfg(2'd1, 2'd0, 1'b1);
    out_ready = 4'b0;
    for (int k = 0; k < 3; k++)
      push1(0, 32'hF000_0000 + 32'(k));
    chk("pre_rst_vld", 32'(out_valid[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", 32'(out_valid), 32'd0);
    chk("rst_mid_rdy", 32'(in_ready), 32'hF);
    chk("rst_mid_cfg", 32'(cfg_out_valid), 32'd0);
`ifdef SWITCH_FWD_CNT_EN
    chk("rst_mid_cnt", 32'(fwd_cnt), 32'd0);
`endif
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 4'hF;
    push1(0, 32'h0BAD_0BAD);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_xbar.md
SWITCH_XBAR -- requirements
Module: switch_xbar

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of input and output ports (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, words per output FIFO (power of two, >=2).
REQ-004 SHALL have parameter CNT_W, default 8, config hop-count width.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: in_valid  in  NUM_PORTS  per-input word valid; in_data  in  NUM_PORTS x DATA_W  per-input word; in_ready  out  NUM_PORTS  per-input accept.
REQ-007 SHALL have ports: out_valid  out  NUM_PORTS  per-output valid; out_data  out  NUM_PORTS x DATA_W  per-output word; out_ready  in  NUM_PORTS  downstream accept.
REQ-008 SHALL have ports: cfg_in_valid  in  1; cfg_in_count  in  CNT_W  hops remaining; cfg_in_port  in  clog2(NUM_PORTS)  target output; cfg_in_src  in  clog2(NUM_PORTS)  source input; cfg_in_enable  in  1. cfg_out_* outputs of identical names and widths.
REQ-009 SHALL, with SWITCH_FWD_CNT_EN defined, add port fwd_cnt  out  NUM_PORTS x 16  per-output forwarded-word count.

Function
REQ-010 Config: cfg_in_valid=1 and cfg_in_count=0 SHALL write enable[cfg_in_port] and src[cfg_in_port] at the next edge; cfg_out_valid=0 next cycle.
REQ-011 Config: cfg_in_valid=1 and cfg_in_count!=0 SHALL register cfg_out with valid=1, count=cfg_in_count-1, port/src/enable unchanged, 1-cycle latency; local state unchanged.
REQ-012 cfg_in_valid=0 SHALL yield cfg_out_valid=0 next cycle and cfg_out_count/port/src/enable=0.
REQ-013 A local config with cfg_in_port or cfg_in_src >= NUM_PORTS SHALL be consumed and ignored.
REQ-014 Each output j SHALL own a FIFO of FIFO_DEPTH words; out_valid[j]=!empty, out_data[j]=head, pop on out_valid&&out_ready.
REQ-015 Push into FIFO j SHALL occur when enable[j]=1 and in_valid[src[j]]&&in_ready[src[j]].
REQ-016 in_ready[i] SHALL be combinational: AND of !full[j] over all j with enable[j]=1 and src[j]=i; 1 if no output selects i (word dropped).
REQ-017 Multicast: one input word SHALL be pushed into every selecting output FIFO in the same cycle, all or none.
REQ-018 Full FIFO SHALL deassert ready even if popped the same cycle (no pop-credit path); empty FIFO SHALL not bypass: accepted word appears on out_data at the next cycle earliest.
REQ-019 Simultaneous push and pop on non-full, non-empty FIFO SHALL keep occupancy constant; pointers wrap modulo FIFO_DEPTH.
REQ-020 Reconfiguration or disable of output j SHALL not flush FIFO j; queued words drain in order, new src applies to subsequent pushes.
REQ-021 Config write and data push in the same cycle SHALL use the pre-write enable/src.

Reset
REQ-022 rst_n=0 SHALL asynchronously clear all enable bits, src to 0, FIFO pointers, cfg_out_* to 0, out_valid to 0, fwd_cnt to 0.
REQ-023 Reset mid-transfer SHALL discard all queued words; in_ready SHALL read 1 for all inputs during reset (no outputs enabled).

Configuration
REQ-024 Macro SWITCH_FWD_CNT_EN defined: per-output 16-bit counter SHALL increment on each pop, saturating at 0xFFFF, cleared only by reset.
REQ-025 Macro undefined: counters and fwd_cnt port SHALL be absent; all other behaviour identical.

Verification
REQ-026 Config count=2 at cycle 0 -> cfg_out valid count=1 at cycle 1, local state unchanged.
REQ-027 Route out2<-in1, push 0xA5A5A5A5 at cycle t, out_ready=1 -> out_valid[2]=1, data 0xA5A5A5A5 at t+1.
REQ-028 Multicast out0,out3<-in2, out_ready[3]=0, push 5 words -> 4 accepted in both FIFOs, in_ready[2]=0 on 5th, out0 sees 4 words only.
REQ-029 Fill out1 FIFO, reroute out1<-in3 -> 4 old words drain in order, then in3 data.
REQ-030 rst_n low for one cycle with 3 words queued -> out_valid=0 immediately, fwd_cnt=0, enables cleared.
